// File: rtl/stage_exe_if.sv
// Decode -> execute -> stage_mem signal bundle for stage_exe.
// The slave modport is the execute stage; the master modport is its environment.
interface stage_exe_if #(
    parameter int unsigned WD_SIZE        = 32,
    parameter int unsigned INSTR_SIZE     = 32,
    parameter int unsigned INSTR_REG_SIZE = 5,
    parameter int unsigned FUNCT3_SIZE    = 3
) ();
    logic                      valid_i;
    logic [INSTR_SIZE-1:0]     pc_i;
    logic [WD_SIZE-1:0]        rs1_data_i;
    logic [WD_SIZE-1:0]        rs2_data_i;
    logic [WD_SIZE-1:0]        imm_i;
    logic [INSTR_REG_SIZE-1:0] rd_i;
    logic [3:0]                ctrl_alu_op_i;
    logic                      ctrl_alu_src_i;
    logic                      ctrl_br_i;
    logic                      ctrl_jm_i;
    logic                      ctrl_jalr_i;
    logic                      ctrl_ld_i;
    logic                      ctrl_st_i;
    logic                      ctrl_reg_write_i;
    logic                      ctrl_mul_i;
    logic [FUNCT3_SIZE-1:0]    ctrl_funct3_i;
    logic                      stall_proc_i;
    logic                      flush_i;

    logic                      mul_busy_o;
    logic [INSTR_SIZE-1:0]     pc_br_o;
    logic [WD_SIZE-1:0]        alu_result_o;
    logic [WD_SIZE-1:0]        rs2_data_o;
    logic                      alu_cmp_o;
    logic [INSTR_REG_SIZE-1:0] rd_o;
    logic [FUNCT3_SIZE-1:0]    ctrl_mem_width_o;
    logic                      ctrl_br_o;
    logic                      ctrl_jm_o;
    logic                      ctrl_ld_o;
    logic                      ctrl_st_o;
    logic                      ctrl_reg_write_o;

    modport slave (
        input  valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i, rd_i, ctrl_alu_op_i,
               ctrl_alu_src_i, ctrl_br_i, ctrl_jm_i, ctrl_jalr_i, ctrl_ld_i, ctrl_st_i,
               ctrl_reg_write_i, ctrl_mul_i, ctrl_funct3_i, stall_proc_i, flush_i,
        output mul_busy_o, pc_br_o, alu_result_o, rs2_data_o, alu_cmp_o, rd_o,
               ctrl_mem_width_o, ctrl_br_o, ctrl_jm_o, ctrl_ld_o, ctrl_st_o, ctrl_reg_write_o
    );

    modport master (
        output valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i, rd_i, ctrl_alu_op_i,
               ctrl_alu_src_i, ctrl_br_i, ctrl_jm_i, ctrl_jalr_i, ctrl_ld_i, ctrl_st_i,
               ctrl_reg_write_i, ctrl_mul_i, ctrl_funct3_i, stall_proc_i, flush_i,
        input  mul_busy_o, pc_br_o, alu_result_o, rs2_data_o, alu_cmp_o, rd_o,
               ctrl_mem_width_o, ctrl_br_o, ctrl_jm_o, ctrl_ld_o, ctrl_st_o, ctrl_reg_write_o
    );
endinterface

// File: rtl/stage_exe.sv
// Execute stage: ALU, branch compare/target, EXE/MEM pipeline register.
// Define STAGE_EXE_MUL_EN to build the iterative 32-cycle shift-add multiplier.
module stage_exe #(
    parameter int unsigned WD_SIZE        = 32,
    parameter int unsigned INSTR_SIZE     = 32,
    parameter int unsigned INSTR_REG_SIZE = 5,
    parameter int unsigned FUNCT3_SIZE    = 3
) (
    input logic       clk,
    input logic       reset_n,
    stage_exe_if.slave bus
);
    localparam int unsigned ShW = $clog2(WD_SIZE);

    typedef struct packed {
        logic [INSTR_SIZE-1:0]     pc_br;
        logic [WD_SIZE-1:0]        alu_result;
        logic [WD_SIZE-1:0]        rs2_data;
        logic                      alu_cmp;
        logic [INSTR_REG_SIZE-1:0] rd;
        logic [FUNCT3_SIZE-1:0]    mem_width;
        logic                      br;
        logic                      jm;
        logic                      ld;
        logic                      st;
        logic                      reg_write;
    } exe_reg_t;

    logic [WD_SIZE-1:0] op_a, op_b, alu_res;
    logic [ShW-1:0]     shamt;
    logic               br_cmp, is_jump;
    exe_reg_t           nxt, exe_d, exe_q;

    always_comb begin
        op_a  = bus.rs1_data_i;
        op_b  = bus.ctrl_alu_src_i ? bus.imm_i : bus.rs2_data_i;
        shamt = op_b[ShW-1:0];
        case (bus.ctrl_alu_op_i)
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res = WD_SIZE'($signed(op_a) < $signed(op_b));
            4'd4:    alu_res = WD_SIZE'(op_a < op_b);
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = op_a + op_b;
        endcase
    end

    // Branch conditions always compare the two register operands, never the immediate.
    always_comb begin
        br_cmp = 1'b0;
        case (bus.ctrl_funct3_i)
            3'b000:  br_cmp = bus.rs1_data_i == bus.rs2_data_i;
            3'b001:  br_cmp = bus.rs1_data_i != bus.rs2_data_i;
            3'b100:  br_cmp = $signed(bus.rs1_data_i) < $signed(bus.rs2_data_i);
            3'b101:  br_cmp = $signed(bus.rs1_data_i) >= $signed(bus.rs2_data_i);
            3'b110:  br_cmp = bus.rs1_data_i < bus.rs2_data_i;
            3'b111:  br_cmp = bus.rs1_data_i >= bus.rs2_data_i;
            default: br_cmp = 1'b0;
        endcase
    end

    always_comb begin
        nxt     = '0;
        is_jump = bus.ctrl_jm_i | bus.ctrl_jalr_i;
        if (bus.valid_i) begin
            nxt.pc_br      = bus.ctrl_jalr_i
                           ? (INSTR_SIZE'(bus.rs1_data_i + bus.imm_i) & ~INSTR_SIZE'(1))
                           : bus.pc_i + INSTR_SIZE'(bus.imm_i);
            nxt.alu_result = is_jump ? WD_SIZE'(bus.pc_i + INSTR_SIZE'(4)) : alu_res;
            nxt.alu_cmp    = is_jump | (bus.ctrl_br_i & br_cmp);
            nxt.rs2_data   = bus.rs2_data_i;
            nxt.rd         = bus.ctrl_reg_write_i ? bus.rd_i : '0;
            nxt.mem_width  = bus.ctrl_funct3_i;
            nxt.br         = bus.ctrl_br_i;
            nxt.jm         = bus.ctrl_jm_i;
            nxt.ld         = bus.ctrl_ld_i;
            nxt.st         = bus.ctrl_st_i;
            nxt.reg_write  = bus.ctrl_reg_write_i;
        end
    end

`ifdef STAGE_EXE_MUL_EN
    typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

    mul_state_e         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WD_SIZE-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    exe_reg_t           held_q, held_d;
    logic               mul_start, mul_busy;

    always_comb begin
        mul_start = (state_q == StIdle) & bus.valid_i & bus.ctrl_mul_i
                  & ~bus.flush_i & ~bus.stall_proc_i;
        mul_busy  = ~bus.flush_i & (mul_start | (state_q == StBusy));
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        held_d    = held_q;
        if (bus.flush_i) begin
            state_d = StIdle;
        end else if (!bus.stall_proc_i) begin
            case (state_q)
                StIdle: begin
                    if (mul_start) begin
                        state_d  = StBusy;
                        cnt_d    = '0;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        prod_d   = '0;
                        held_d   = nxt;
                    end
                end
                StBusy: begin
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = StDone;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // DONE publishes the product with the control captured when the multiply began.
    always_comb begin
        exe_d = exe_q;
        if (bus.flush_i) begin
            exe_d = '0;
        end else if (!bus.stall_proc_i) begin
            if (state_q == StDone) begin
                exe_d            = held_q;
                exe_d.alu_result = prod_q;
            end else if (mul_busy) begin
                exe_d = '0;
            end else begin
                exe_d = nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            held_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            held_q   <= held_d;
        end
    end

    assign bus.mul_busy_o = mul_busy;
`else
    logic unused_mul;
    assign unused_mul = bus.ctrl_mul_i;

    always_comb begin
        exe_d = exe_q;
        if (bus.flush_i)              exe_d = '0;
        else if (!bus.stall_proc_i)   exe_d = nxt;
    end

    assign bus.mul_busy_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) exe_q <= '0;
        else          exe_q <= exe_d;
    end

    assign bus.pc_br_o          = exe_q.pc_br;
    assign bus.alu_result_o     = exe_q.alu_result;
    assign bus.rs2_data_o       = exe_q.rs2_data;
    assign bus.alu_cmp_o        = exe_q.alu_cmp;
    assign bus.rd_o             = exe_q.rd;
    assign bus.ctrl_mem_width_o = exe_q.mem_width;
    assign bus.ctrl_br_o        = exe_q.br;
    assign bus.ctrl_jm_o        = exe_q.jm;
    assign bus.ctrl_ld_o        = exe_q.ld;
    assign bus.ctrl_st_o        = exe_q.st;
    assign bus.ctrl_reg_write_o = exe_q.reg_write;
endmodule

// File: tb/tb_stage_exe.sv
// Self-checking bench for stage_exe: behavioural model compared every cycle plus
// hand-computed spot checks. Multiplier tests run when STAGE_EXE_MUL_EN is defined.
module tb_stage_exe;
`ifdef STAGE_EXE_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        src, br, jm, jalr, ld, st, rw, mul;
        logic [2:0]  f3;
    } instr_t;

    typedef struct packed {
        logic [31:0] pc_br, alu, rs2;
        logic        cmp;
        logic [4:0]  rd;
        logic [2:0]  mw;
        logic        br, jm, ld, st, rw;
    } out_t;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    instr_t cur = '0;
    logic   stall = 1'b0;
    logic   flush = 1'b0;
    int     checks = 0;
    int     errs = 0;

    always #5 clk = ~clk;

    stage_exe_if #(.WD_SIZE(32), .INSTR_SIZE(32), .INSTR_REG_SIZE(5), .FUNCT3_SIZE(3)) bus ();

    stage_exe #(.WD_SIZE(32), .INSTR_SIZE(32), .INSTR_REG_SIZE(5), .FUNCT3_SIZE(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.valid_i          = cur.valid;
    assign bus.pc_i             = cur.pc;
    assign bus.rs1_data_i       = cur.rs1;
    assign bus.rs2_data_i       = cur.rs2;
    assign bus.imm_i            = cur.imm;
    assign bus.rd_i             = cur.rd;
    assign bus.ctrl_alu_op_i    = cur.op;
    assign bus.ctrl_alu_src_i   = cur.src;
    assign bus.ctrl_br_i        = cur.br;
    assign bus.ctrl_jm_i        = cur.jm;
    assign bus.ctrl_jalr_i      = cur.jalr;
    assign bus.ctrl_ld_i        = cur.ld;
    assign bus.ctrl_st_i        = cur.st;
    assign bus.ctrl_reg_write_i = cur.rw;
    assign bus.ctrl_mul_i       = cur.mul;
    assign bus.ctrl_funct3_i    = cur.f3;
    assign bus.stall_proc_i     = stall;
    assign bus.flush_i          = flush;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // What a single instruction should leave in the EXE/MEM register.
    function automatic out_t model(instr_t i);
        out_t        o = '0;
        logic [31:0] b;
        logic        lt, ltu;
        if (!i.valid) return o;
        b   = i.src ? i.imm : i.rs2;
        lt  = $signed(i.rs1) < $signed(i.rs2);
        ltu = i.rs1 < i.rs2;
        case (i.op)
            4'd1:    o.alu = i.rs1 - b;
            4'd2:    o.alu = i.rs1 << b[4:0];
            4'd3:    o.alu = ($signed(i.rs1) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    o.alu = (i.rs1 < b) ? 32'd1 : 32'd0;
            4'd5:    o.alu = i.rs1 ^ b;
            4'd6:    o.alu = i.rs1 >> b[4:0];
            4'd7:    o.alu = $signed(i.rs1) >>> b[4:0];
            4'd8:    o.alu = i.rs1 | b;
            4'd9:    o.alu = i.rs1 & b;
            4'd10:   o.alu = b;
            default: o.alu = i.rs1 + b;
        endcase
        if (MulEn && i.mul) o.alu = i.rs1 * b;
        o.pc_br = i.jalr ? ((i.rs1 + i.imm) & 32'hFFFF_FFFE) : i.pc + i.imm;
        if (i.jm || i.jalr) begin
            o.alu = i.pc + 32'd4;
            o.cmp = 1'b1;
        end else if (i.br) begin
            case (i.f3)
                3'd0:    o.cmp = i.rs1 == i.rs2;
                3'd1:    o.cmp = i.rs1 != i.rs2;
                3'd4:    o.cmp = lt;
                3'd5:    o.cmp = !lt;
                3'd6:    o.cmp = ltu;
                3'd7:    o.cmp = !ltu;
                default: o.cmp = 1'b0;
            endcase
        end
        o.rs2 = i.rs2;
        o.rd  = i.rw ? i.rd : 5'd0;
        o.mw  = i.f3;
        o.br  = i.br;
        o.jm  = i.jm;
        o.ld  = i.ld;
        o.st  = i.st;
        o.rw  = i.rw;
        return o;
    endfunction

    // Pipeline model: m_age counts unstalled cycles since the multiply was accepted.
    out_t m_exp, m_held;
    logic m_pend;
    int   m_age;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_exp  <= '0;
            m_held <= '0;
            m_pend <= 1'b0;
            m_age  <= 0;
        end else if (flush) begin
            m_exp  <= '0;
            m_pend <= 1'b0;
        end else if (!stall) begin
            if (m_pend && m_age == 33) begin
                m_exp  <= m_held;
                m_pend <= 1'b0;
            end else if (m_pend) begin
                m_exp <= '0;
                m_age <= m_age + 1;
            end else if (MulEn && cur.valid && cur.mul) begin
                m_pend <= 1'b1;
                m_age  <= 1;
                m_held <= model(cur);
                m_exp  <= '0;
            end else begin
                m_exp <= model(cur);
            end
        end
    end

    always @(negedge clk) begin
        logic exp_busy;
        if (reset_n) begin
            exp_busy = MulEn && !flush &&
                       ((m_pend && m_age <= 32) || (!m_pend && cur.valid && cur.mul && !stall));
            chk("pc_br", bus.pc_br_o, m_exp.pc_br);
            chk("alu_result", bus.alu_result_o, m_exp.alu);
            chk("rs2_data", bus.rs2_data_o, m_exp.rs2);
            chk("alu_cmp", 32'(bus.alu_cmp_o), 32'(m_exp.cmp));
            chk("rd", 32'(bus.rd_o), 32'(m_exp.rd));
            chk("mem_width", 32'(bus.ctrl_mem_width_o), 32'(m_exp.mw));
            chk("ctrl_br", 32'(bus.ctrl_br_o), 32'(m_exp.br));
            chk("ctrl_jm", 32'(bus.ctrl_jm_o), 32'(m_exp.jm));
            chk("ctrl_ld", 32'(bus.ctrl_ld_o), 32'(m_exp.ld));
            chk("ctrl_st", 32'(bus.ctrl_st_o), 32'(m_exp.st));
            chk("ctrl_reg_write", 32'(bus.ctrl_reg_write_o), 32'(m_exp.rw));
            chk("mul_busy", 32'(bus.mul_busy_o), 32'(exp_busy));
        end
    end

    task automatic issue(input instr_t i, input logic st, input logic fl);
        @(posedge clk);
        #1;
        cur   = i;
        stall = st;
        flush = fl;
    endtask

    function automatic instr_t alu_i(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                     logic [31:0] imm, logic src, logic [4:0] rd);
        instr_t i = '0;
        i.valid = 1'b1;
        i.pc    = 32'h10;
        i.op    = op;
        i.rs1   = a;
        i.rs2   = b;
        i.imm   = imm;
        i.src   = src;
        i.rd    = rd;
        i.rw    = 1'b1;
        return i;
    endfunction

    function automatic instr_t br_i(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                    logic [31:0] pc, logic [31:0] imm);
        instr_t i = alu_i(4'd0, a, b, imm, 1'b0, 5'd0);
        i.rw = 1'b0;
        i.br = 1'b1;
        i.f3 = f3;
        i.pc = pc;
        return i;
    endfunction

    // Issue one instruction, then a bubble, and check its ALU result.
    task automatic lit_alu(input instr_t i, input string nm, input logic [31:0] exp);
        issue(i, 1'b0, 1'b0);
        issue('0, 1'b0, 1'b0);
        #2 chk(nm, bus.alu_result_o, exp);
    endtask

    instr_t nop = '0;
    instr_t t, add_a, add_b, mul_i;
    instr_t vec[12];
    int     busy_cnt;

    initial begin
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Reset asserted mid-cycle clears outputs without waiting for a clock.
        issue(alu_i(4'd8, 32'h00F0, 32'h0F00, 32'h0, 1'b0, 5'd9), 1'b0, 1'b0);
        @(posedge clk);
        #3 chk("pre_reset_or", bus.alu_result_o, 32'h0FF0);
        reset_n = 1'b0;
        cur     = nop;
        #1;
        chk("reset_alu", bus.alu_result_o, 32'h0);
        chk("reset_rd", 32'(bus.rd_o), 32'h0);
        chk("reset_rw", 32'(bus.ctrl_reg_write_o), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        lit_alu(alu_i(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1), "add_5_7", 32'd12);
        lit_alu(alu_i(4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd2), "sra", 32'hF800_0000);
        lit_alu(alu_i(4'd10, 32'd9, 32'd9, 32'h1234, 1'b1, 5'd2), "pass_b_imm", 32'h1234);
        lit_alu(alu_i(4'd15, 32'd1, 32'd2, 32'd0, 1'b0, 5'd2), "op15_add", 32'd3);
        lit_alu(alu_i(4'd2, 32'd3, 32'h21, 32'd0, 1'b0, 5'd2), "sll_mask", 32'd6);

        // Back-to-back ALU stream, checked by the model only.
        vec[0]  = alu_i(4'd1, 32'd10, 32'd3, 32'd0, 1'b0, 5'd3);
        vec[1]  = alu_i(4'd2, 32'd1, 32'd0, 32'd31, 1'b1, 5'd4);
        vec[2]  = alu_i(4'd3, 32'hFFFF_FFFB, 32'd2, 32'd0, 1'b0, 5'd5);
        vec[3]  = alu_i(4'd4, 32'hFFFF_FFFB, 32'd2, 32'd0, 1'b0, 5'd6);
        vec[4]  = alu_i(4'd5, 32'hA5A5_0000, 32'h0F0F_FFFF, 32'd0, 1'b0, 5'd7);
        vec[5]  = alu_i(4'd6, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd8);
        vec[6]  = alu_i(4'd9, 32'hF0F0_1234, 32'hFF00_FF00, 32'd0, 1'b0, 5'd9);
        vec[7]  = br_i(3'd0, 32'd7, 32'd7, 32'h300, 32'h10);
        vec[8]  = br_i(3'd1, 32'd7, 32'd7, 32'h300, 32'hFFFF_FFF0);
        vec[9]  = br_i(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h8);
        vec[10] = br_i(3'd2, 32'd1, 32'd1, 32'h300, 32'h8);
        vec[11] = vec[3];
        vec[11].valid = 1'b0;
        for (int k = 0; k < 12; k++) issue(vec[k], 1'b0, 1'b0);

        issue(br_i(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20), 1'b0, 1'b0);
        issue(br_i(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20), 1'b0, 1'b0);
        #2;
        chk("blt_cmp", 32'(bus.alu_cmp_o), 32'd1);
        chk("blt_target", bus.pc_br_o, 32'h120);
        issue(nop, 1'b0, 1'b0);
        #2 chk("bltu_cmp", 32'(bus.alu_cmp_o), 32'd0);

        t = alu_i(4'd0, 32'h1001, 32'd0, 32'd4, 1'b1, 5'd1);
        t.pc = 32'h40; t.jm = 1'b1; t.jalr = 1'b1;
        issue(t, 1'b0, 1'b0);
        t = alu_i(4'd0, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b1, 5'd1);
        t.pc = 32'h200; t.jm = 1'b1;
        issue(t, 1'b0, 1'b0);
        #2;
        chk("jalr_target", bus.pc_br_o, 32'h1004);
        chk("jalr_link", bus.alu_result_o, 32'h44);
        chk("jalr_jm", 32'(bus.ctrl_jm_o), 32'd1);
        issue(nop, 1'b0, 1'b0);
        #2 chk("jal_target", bus.pc_br_o, 32'h1F8);

        t = alu_i(4'd0, 32'h1000, 32'd0, 32'd8, 1'b1, 5'd3);
        t.ld = 1'b1; t.f3 = 3'd2;
        issue(t, 1'b0, 1'b0);
        t = alu_i(4'd0, 32'h1000, 32'hCAFE, 32'd4, 1'b1, 5'd7);
        t.st = 1'b1; t.rw = 1'b0; t.f3 = 3'd1;
        issue(t, 1'b0, 1'b0);
        issue(nop, 1'b0, 1'b0);
        #2 chk("store_rd_zero", 32'(bus.rd_o), 32'd0);
        issue(vec[0], 1'b0, 1'b1);

        // Stall held for three cycles: register holds, next instruction follows.
        add_a = alu_i(4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 5'd4);
        add_b = alu_i(4'd1, 32'd50, 32'd8, 32'd0, 1'b0, 5'd5);
        issue(add_a, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            issue(add_b, 1'b1, 1'b0);
            #2 chk("stall_hold", bus.alu_result_o, 32'd123);
        end
        issue(add_b, 1'b0, 1'b0);
        issue(nop, 1'b0, 1'b0);
        #2 chk("after_stall", bus.alu_result_o, 32'd42);

        mul_i = alu_i(4'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 5'd6);
        mul_i.mul = 1'b1;
`ifdef STAGE_EXE_MUL_EN
        for (int run = 0; run < 2; run++) begin
            busy_cnt = 0;
            for (int k = 0; k < 34 + 4 * run; k++) begin
                issue(mul_i, (run == 1) && (k >= 10) && (k < 14), 1'b0);
                #2 if (bus.mul_busy_o) busy_cnt++;
                if (k == 33 + 4 * run) chk("mul_bubble", bus.alu_result_o, 32'd0);
            end
            issue(nop, 1'b0, 1'b0);
            #2;
            chk("mul_result", bus.alu_result_o, 32'hFFFF_FFFD);
            chk("mul_rd", 32'(bus.rd_o), 32'd6);
            chk("mul_busy_cycles", 32'(busy_cnt), (run == 1) ? 32'd37 : 32'd33);
        end

        for (int k = 0; k <= 10; k++) begin
            issue(mul_i, 1'b0, k == 10);
            if (k == 10) #2 chk("flush_busy", 32'(bus.mul_busy_o), 32'd0);
        end
        issue(add_a, 1'b0, 1'b0);
        #2 chk("flush_bubble", bus.alu_result_o, 32'd0);
        issue(nop, 1'b0, 1'b0);
        #2 chk("add_after_flush", bus.alu_result_o, 32'd123);

        for (int k = 0; k < 6; k++) issue(mul_i, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        cur     = nop;
        #1 chk("reset_mid_mul_busy", 32'(bus.mul_busy_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(add_a, 1'b0, 1'b0);
        issue(nop, 1'b0, 1'b0);
        #2 chk("add_after_abort", bus.alu_result_o, 32'd123);
`else
        issue(mul_i, 1'b0, 1'b0);
        #2 chk("no_mul_busy", 32'(bus.mul_busy_o), 32'd0);
        issue(nop, 1'b0, 1'b0);
        #2 chk("no_mul_as_add", bus.alu_result_o, 32'd2);
`endif
        repeat (2) issue(nop, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
